frame_windower: RTL and testbench

FRAME_WINDOWER -- requirements
Module: frame_windower

---
 rtl/frame_windower_if.sv | 52 +++++
 rtl/frame_windower.sv | 156 +++++++++++++++
 tb/tb_frame_windower.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_windower_if.sv
// Sample-buffer, coefficient-ROM and output-stream bundle
// for the frame windower.
interface frame_windower_if #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int COEF_WIDTH = 16
);
    localparam int AW = $clog2(FRAME_SIZE);

    logic                  buf_rd_en_o;
    logic [WIDTH-1:0]      buf_data_i;
    logic                  buf_valid_i;
    logic                  buf_idle_i;
    logic                  buf_start_move_o;
    logic [AW-1:0]         coef_addr_o;
    logic [COEF_WIDTH-1:0] coef_i;
    logic [WIDTH-1:0]      out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_last_o;
    logic                  frame_done_o;

    modport master (
        output buf_rd_en_o,
        output buf_start_move_o,
        output coef_addr_o,
        output out_data_o,
        output out_valid_o,
        output out_last_o,
        output frame_done_o,
        input  buf_data_i,
        input  buf_valid_i,
        input  buf_idle_i,
        input  coef_i,
        input  out_ready_i
    );

    modport slave (
        input  buf_rd_en_o,
        input  buf_start_move_o,
        input  coef_addr_o,
        input  out_data_o,
        input  out_valid_o,
        input  out_last_o,
        input  frame_done_o,
        output buf_data_i,
        output buf_valid_i,
        output buf_idle_i,
        output coef_i,
        output out_ready_i
    );
endinterface

// File: rtl/frame_windower.sv
// Reads one frame from the window buffer, multiplies each sample by
// its window coefficient, streams it out and then slides the buffer.
module frame_windower #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int COEF_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    frame_windower_if.master bus
);
    localparam int AW = $clog2(FRAME_SIZE);
    localparam int IW = $clog2(FRAME_SIZE + 1);
    localparam int PW = WIDTH + COEF_WIDTH + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);
    localparam logic [IW-1:0] FULL_IDX = IW'(FRAME_SIZE);

    localparam logic signed [PW-1:0] RND =
        PW'(1) << (COEF_WIDTH - 2);
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_BUF,
        MOVE
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_s1_data;
    logic              r_s1_last;
    logic [AW-1:0]     r_addr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_last;
    logic              r_move;
    logic              r_done;

    logic              w_advance;
    logic              w_rd_en;
    logic              w_consume;
    logic              w_accept;
    logic signed [PW-1:0] w_sample;
    logic signed [PW-1:0] w_coef;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic [WIDTH-1:0]  w_sat;

    assign w_advance = !r_out_valid || bus.out_ready_i;
    assign w_rd_en   = (r_state == READ) && w_advance &&
                       (r_idx < FULL_IDX);
    assign w_consume = w_rd_en && bus.buf_valid_i;
    assign w_accept  = r_out_valid && bus.out_ready_i;

    // coef_i belongs to r_addr, which moves together with stage 1
    assign w_sample = {{(PW-WIDTH){r_s1_data[WIDTH-1]}}, r_s1_data};
    assign w_coef   = {{(PW-COEF_WIDTH){1'b0}}, bus.coef_i};
    assign w_prod   = w_sample * w_coef;
    assign w_shift  = (w_prod + RND) >>> (COEF_WIDTH - 1);

    always_comb begin
        w_sat = w_shift[WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_last   <= 1'b0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_move      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_move <= 1'b0;
            r_done <= w_accept && r_out_last;

            unique case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_state <= READ;
                        r_idx   <= '0;
                    end
                end
                READ: begin
                    if (w_consume && r_idx == LAST_IDX) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_accept && r_out_last && !r_s1_valid) begin
                        r_state <= WAIT_BUF;
                    end
                end
                WAIT_BUF: begin
                    if (bus.buf_idle_i) begin
                        if (enable_i) begin
                            r_state <= MOVE;
                            r_move  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                MOVE: begin
                    r_state <= READ;
                    r_idx   <= '0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_consume) begin
                r_idx <= r_idx + IW'(1);
            end

            if (w_advance) begin
                r_s1_valid <= w_consume;
                if (w_consume) begin
                    r_s1_data <= bus.buf_data_i;
                    r_s1_last <= (r_idx == LAST_IDX);
                    r_addr    <= AW'(r_idx);
                end
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_sat;
                    r_out_last <= r_s1_last;
                end
            end
        end
    end

    assign bus.buf_rd_en_o      = w_rd_en;
    assign bus.buf_start_move_o = r_move;
    assign bus.coef_addr_o      = r_addr;
    assign bus.out_data_o       = r_out_data;
    assign bus.out_valid_o      = r_out_valid;
    assign bus.out_last_o       = r_out_last;
    assign bus.frame_done_o     = r_done;
endmodule

// File: tb/tb_frame_windower.sv
// Randomized bench for frame_windower with a queue-based
// reference model of frames, windowing arithmetic and handshakes.
module tb_frame_windower;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_nxt = 1'b0;
    logic enable_i = 1'b0;

    always #5 clk = ~clk;

    frame_windower_if #(
        .WIDTH(W), .FRAME_SIZE(N), .COEF_WIDTH(CW)
    ) bus ();

    frame_windower #(
        .WIDTH(W), .FRAME_SIZE(N), .COEF_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_i(enable_i),
        .bus(bus)
    );

    logic [CW-1:0] rom [N];
    assign bus.coef_i = rom[bus.coef_addr_o];

    typedef struct {
        logic signed [W-1:0] d;
        logic                l;
    } exp_t;

    exp_t                exp_q[$];
    logic signed [W-1:0] src_q[$];

    int n_chk = 0;
    int n_err = 0;
    int p_valid = 100;
    int p_ready = 100;
    int p_idle = 100;
    int lo_cnt = 0;
    int cyc = 0;
    int ncons = 0;
    int ndone = 0;
    int nmove = 0;
    int first_cyc = -1;
    bit lat_chk = 0;
    bit lat_done = 0;
    bit pend_done = 0;
    bit prev_stall = 0;
    bit rst_prev = 0;
    logic signed [W-1:0] prev_d;
    logic prev_l;

    task automatic check(string tag, logic signed [63:0] got,
                         logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Q1.15 window gain, round half up, saturate to W bits
    function automatic logic signed [W-1:0] ref_win(
        logic signed [W-1:0] s, logic [CW-1:0] c);
        longint p;
        p = longint'(s) * longint'(c) + (longint'(1) <<< (CW - 2));
        p = p >>> (CW - 1);
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return W'(p);
    endfunction

    task automatic drive();
        rst_n = rst_n_nxt;
        bus.buf_valid_i = (src_q.size() > 0) &&
                          ($urandom_range(99) < p_valid);
        bus.buf_data_i = bus.buf_valid_i ? src_q[0] : W'($urandom);
        if (lo_cnt > 0) begin
            bus.out_ready_i = 1'b0;
            lo_cnt--;
        end else begin
            bus.out_ready_i = $urandom_range(99) < p_ready;
        end
        bus.buf_idle_i = $urandom_range(99) < p_idle;
    endtask

    task automatic observe();
        exp_t e;
        int   k;
        cyc++;
        if (rst_prev) begin
            check("rst_rd_en", bus.buf_rd_en_o, 0);
            check("rst_move", bus.buf_start_move_o, 0);
            check("rst_addr", bus.coef_addr_o, 0);
            check("rst_data", bus.out_data_o, 0);
            check("rst_valid", bus.out_valid_o, 0);
            check("rst_last", bus.out_last_o, 0);
            check("rst_done", bus.frame_done_o, 0);
            rst_prev = 0;
        end
        if (!rst_n) begin
            exp_q.delete();
            pend_done = 0;
            prev_stall = 0;
            ncons = 0;
            first_cyc = -1;
            rst_prev = 1;
            return;
        end
        check("done", bus.frame_done_o, pend_done);
        pend_done = 0;
        if (bus.frame_done_o) ndone++;
        if (bus.buf_start_move_o) nmove++;
        if (prev_stall) begin
            check("hold_valid", bus.out_valid_o, 1);
            check("hold_data", $signed(bus.out_data_o), prev_d);
            check("hold_last", bus.out_last_o, prev_l);
        end
        if (bus.out_valid_o && !bus.out_ready_i)
            check("rd_en_stall", bus.buf_rd_en_o, 0);
        if (lat_chk && !lat_done && bus.out_valid_o) begin
            check("latency", cyc - first_cyc, 2);
            lat_done = 1;
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", $signed(bus.out_data_o), e.d);
                check("last", bus.out_last_o, e.l);
                pend_done = e.l;
            end
        end
        if (bus.buf_rd_en_o && bus.buf_valid_i) begin
            k = ncons % N;
            e.d = ref_win(bus.buf_data_i, rom[k]);
            e.l = (k == N - 1);
            exp_q.push_back(e);
            void'(src_q.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            ncons++;
        end
        prev_stall = bus.out_valid_o && !bus.out_ready_i;
        prev_d = bus.out_data_o;
        prev_l = bus.out_last_o;
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        observe();
    endtask

    task automatic do_reset();
        enable_i = 1'b0;
        rst_n_nxt = 1'b0;
        tick();
        tick();
        rst_n_nxt = 1'b1;
        tick();
        src_q.delete();
        ndone = 0;
        nmove = 0;
    endtask

    task automatic run_frames(int target, int bound);
        for (int k = 0; k < bound && ndone < target; k++) tick();
        check("frames", ndone, target);
    endtask

    task automatic load_random(int frames);
        for (int i = 0; i < frames * N; i++)
            src_q.push_back(W'($urandom));
    endtask

    initial begin
        logic signed [W-1:0] ar_s [N];
        logic [CW-1:0]       ar_c [N];
        ar_s = '{1000, 3, 32767, -32768, -3, 5, -32768, 32767};
        ar_c = '{16'h4000, 16'h4000, 16'h8000, 16'h8000,
                 16'h4000, 16'h8000, 16'hFFFF, 16'hFFFF};
        bus.buf_valid_i = 1'b0;
        bus.buf_data_i = '0;
        bus.buf_idle_i = 1'b0;
        bus.out_ready_i = 1'b0;
        foreach (rom[i]) rom[i] = 16'h8000;

        do_reset();
        for (int i = 1; i <= N; i++) src_q.push_back(W'(i));
        lat_chk = 1;
        enable_i = 1'b1;
        run_frames(1, 200);
        repeat (4) tick();
        check("move_once", nmove, 1);
        check("drained", exp_q.size(), 0);
        lat_chk = 0;

        do_reset();
        foreach (rom[i]) rom[i] = ar_c[i];
        foreach (ar_s[i]) src_q.push_back(ar_s[i]);
        enable_i = 1'b1;
        run_frames(1, 200);
        check("arith_drained", exp_q.size(), 0);

        do_reset();
        foreach (rom[i]) rom[i] = CW'($urandom);
        load_random(6);
        p_valid = 70;
        p_ready = 70;
        p_idle = 60;
        enable_i = 1'b1;
        for (int k = 0; k < 400 && ncons < 12; k++) tick();
        lo_cnt = 5;
        run_frames(6, 3000);
        p_idle = 100;
        repeat (5) tick();
        check("rand_moves", nmove, 6);
        check("rand_drained", exp_q.size(), 0);

        do_reset();
        p_valid = 100;
        p_ready = 100;
        p_idle = 0;
        load_random(2);
        enable_i = 1'b1;
        run_frames(1, 200);
        repeat (10) tick();
        check("move_wait", nmove, 0);
        check("no_read_wait", ncons, N);
        p_idle = 100;
        repeat (4) tick();
        check("move_after_idle", nmove, 1);
        run_frames(2, 200);
        check("second_frame", ncons, 2 * N);

        do_reset();
        foreach (rom[i]) rom[i] = CW'($urandom);
        load_random(1);
        enable_i = 1'b1;
        for (int k = 0; k < 100 && ncons < 4; k++) tick();
        check("pre_rst_cons", ncons, 4);
        rst_n_nxt = 1'b0;
        enable_i = 1'b0;
        tick();
        tick();
        rst_n_nxt = 1'b1;
        tick();
        check("rst_no_done", ndone, 0);
        check("rst_no_move", nmove, 0);
        src_q.delete();
        load_random(1);
        enable_i = 1'b1;
        run_frames(1, 200);
        check("fresh_frame", ncons, N);
        check("fresh_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
